// File: rtl/mealy_table_fsm_if.sv
// Host-side bundle for mealy_table_fsm: table config, run control, and observed status.
// The host drives through the master modport; the FSM connects through the slave modport.
interface mealy_table_fsm_if #(
    parameter int STATE_W = 3,
    parameter int IN_W    = 2,
    parameter int OUT_W   = 1,
    parameter int CNT_W   = 16
);
    logic                    cfg_we;
    logic [STATE_W+IN_W-1:0] cfg_addr;
    logic [STATE_W-1:0]      cfg_next;
    logic [OUT_W-1:0]        cfg_out;
    logic [STATE_W-1:0]      init_state;
    logic                    arm;
    logic                    disarm;
    logic                    step;
    logic [IN_W-1:0]         sw_in;
    logic [STATE_W-1:0]      state;
    logic [OUT_W-1:0]        out;
    logic                    out_valid;
    logic [1:0]              mode;
    logic                    illegal;
    logic                    cfg_err;
    logic [CNT_W-1:0]        step_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_next, cfg_out, init_state, arm, disarm, step, sw_in,
        input  state, out, out_valid, mode, illegal, cfg_err, step_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_next, cfg_out, init_state, arm, disarm, step, sw_in,
        output state, out, out_valid, mode, illegal, cfg_err, step_cnt
    );
endinterface

// File: rtl/mealy_table_fsm.sv
// Programmable table-driven Mealy machine: table loaded in CFG, stepped on sw_in in RUN.
// Optional MEALY_STEP_CNT_EN adds a saturating executed-step counter on step_cnt.
module mealy_table_fsm #(
    parameter int STATE_W    = 3,
    parameter int NUM_STATES = 3,
    parameter int IN_W       = 2,
    parameter int OUT_W      = 1,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    mealy_table_fsm_if.slave bus
);
    localparam int ADDR_W = STATE_W + IN_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int ENT_W  = STATE_W + OUT_W;
    localparam logic [STATE_W:0] NUM_STATES_L = NUM_STATES[STATE_W:0];

    localparam logic [1:0] MODE_CFG  = 2'd0;
    localparam logic [1:0] MODE_RUN  = 2'd1;
    localparam logic [1:0] MODE_HALT = 2'd2;

    logic [ENT_W-1:0]   tbl_q [DEPTH];
    logic [DEPTH-1:0]   valid_q,     valid_d;
    logic [1:0]         mode_q,      mode_d;
    logic [STATE_W-1:0] state_q,     state_d;
    logic [OUT_W-1:0]   out_q,       out_d;
    logic               out_valid_q, out_valid_d;
    logic               illegal_q,   illegal_d;
    logic               cfg_err_q,   cfg_err_d;

    logic               tbl_we;
    logic               step_ok;
    logic               arm_ok;
    logic [ADDR_W-1:0]  rd_addr;
    logic [STATE_W-1:0] ent_next;
    logic [OUT_W-1:0]   ent_out;
    logic               ent_ok;
    logic               next_ok;
    logic               init_ok;

    assign rd_addr             = {state_q, bus.sw_in};
    assign {ent_next, ent_out} = tbl_q[rd_addr];
    assign ent_ok  = valid_q[rd_addr] && ({1'b0, ent_next} < NUM_STATES_L);
    assign next_ok = {1'b0, bus.cfg_next} < NUM_STATES_L;
    assign init_ok = {1'b0, bus.init_state} < NUM_STATES_L;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        mode_d      = mode_q;
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        illegal_d   = illegal_q;
        cfg_err_d   = cfg_err_q;
        valid_d     = valid_q;
        tbl_we      = 1'b0;
        step_ok     = 1'b0;
        arm_ok      = 1'b0;
        case (mode_q)
            MODE_CFG: begin
                if (bus.arm) begin
                    if (init_ok) begin
                        arm_ok    = 1'b1;
                        state_d   = bus.init_state;
                        out_d     = '0;
                        illegal_d = 1'b0;
                        cfg_err_d = 1'b0;
                        mode_d    = MODE_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                // A bad write in the arm cycle still flags, overriding the arm clear.
                if (bus.cfg_we) begin
                    if (next_ok) begin
                        tbl_we            = 1'b1;
                        valid_d[bus.cfg_addr] = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            MODE_RUN: begin
                if (bus.cfg_we) cfg_err_d = 1'b1;
                if (bus.step) begin
                    if (ent_ok) begin
                        step_ok     = 1'b1;
                        state_d     = ent_next;
                        out_d       = ent_out;
                        out_valid_d = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                        mode_d    = MODE_HALT;
                    end
                end
                if (bus.disarm) mode_d = MODE_CFG;
            end
            MODE_HALT: begin
                if (bus.cfg_we)  cfg_err_d = 1'b1;
                if (bus.disarm)  mode_d    = MODE_CFG;
            end
            default: mode_d = MODE_CFG;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_CFG;
            state_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            valid_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            cfg_err_q   <= cfg_err_d;
            valid_q     <= valid_d;
        end
    end

    // NOTE: table data has no reset; the cleared valid bits make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (tbl_we) tbl_q[bus.cfg_addr] <= {bus.cfg_next, bus.cfg_out};
    end

`ifdef MEALY_STEP_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (arm_ok)                       cnt_d = '0;
        else if (step_ok && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.step_cnt = cnt_q;
`else
    assign bus.step_cnt = '0;
`endif

    assign bus.state     = state_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.mode      = mode_q;
    assign bus.illegal   = illegal_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule
